// File: rtl/div_sequencer.sv
// div_sequencer: multi-cycle radix-2 restoring divider for RV32M
// DIV/DIVU/REM/REMU. It accepts a request from EX, stalls the pipeline
// while it produces one quotient bit per cycle, fixes the signs, and then
// pulses done with the result.
module div_sequencer #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            flush,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    output logic            stall,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);

    localparam int CW = $clog2(XLEN) + 1;
    localparam logic [CW-1:0]   CNT_INIT = CW'(XLEN);
    localparam logic [XLEN-1:0] INT_MIN  = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [XLEN-1:0] rem_q, rem_d;
    logic [XLEN-1:0] quo_q, quo_d;
    logic [XLEN-1:0] dvs_q, dvs_d;
    logic [XLEN-1:0] result_q, result_d;
    logic            sign_a_q, sign_a_d;
    logic            sign_b_q, sign_b_d;
    logic            want_rem_q, want_rem_d;

    logic            accept;
    logic            is_signed;
    logic [XLEN-1:0] abs_a;
    logic [XLEN-1:0] abs_b;
    logic [XLEN:0]   rem_sh;
    logic            ge;
    logic [XLEN-1:0] trial;

    // Next-state, datapath update and combinational outputs.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        rem_d      = rem_q;
        quo_d      = quo_q;
        dvs_d      = dvs_q;
        result_d   = result_q;
        sign_a_d   = sign_a_q;
        sign_b_d   = sign_b_q;
        want_rem_d = want_rem_q;
        stall      = 1'b0;

        accept    = start & funct3[2] & ~flush;
        is_signed = ~funct3[0];
        abs_a     = (is_signed & op_a[XLEN-1]) ? -op_a : op_a;
        abs_b     = (is_signed & op_b[XLEN-1]) ? -op_b : op_b;

        // Shift {rem,quo} left by one and trial-subtract the divisor. The
        // shifted remainder is below 2*divisor, so the low XLEN bits of the
        // difference are exact whenever the subtraction does not borrow.
        rem_sh = {rem_q, quo_q[XLEN-1]};
        ge     = (rem_sh >= {1'b0, dvs_q});
        trial  = rem_sh[XLEN-1:0] - dvs_q;

        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    stall      = 1'b1;
                    sign_a_d   = is_signed & op_a[XLEN-1];
                    sign_b_d   = is_signed & op_b[XLEN-1];
                    want_rem_d = funct3[1];
                    dvs_d      = abs_b;
                    if (op_b == '0) begin
                        result_d = funct3[1] ? op_a : '1;
                        state_d  = DONE;
                    end else if (is_signed && op_a == INT_MIN && op_b == '1) begin
                        result_d = funct3[1] ? '0 : INT_MIN;
                        state_d  = DONE;
                    end else begin
                        rem_d   = '0;
                        quo_d   = abs_a;
                        cnt_d   = CNT_INIT;
                        state_d = CALC;
                    end
                end
            end
            CALC: begin
                stall = 1'b1;
                if (flush) begin
                    state_d = IDLE;
                end else begin
                    rem_d = ge ? trial : rem_sh[XLEN-1:0];
                    quo_d = {quo_q[XLEN-2:0], ge};
                    cnt_d = cnt_q - CW'(1);
                    if (cnt_q == CW'(1)) begin
                        state_d = FIX;
                    end
                end
            end
            FIX: begin
                stall = 1'b1;
                if (flush) begin
                    state_d = IDLE;
                end else begin
                    if (want_rem_q) begin
                        result_d = sign_a_q ? -rem_q : rem_q;
                    end else begin
                        result_d = (sign_a_q ^ sign_b_q) ? -quo_q : quo_q;
                    end
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            rem_q      <= '0;
            quo_q      <= '0;
            dvs_q      <= '0;
            result_q   <= '0;
            sign_a_q   <= 1'b0;
            sign_b_q   <= 1'b0;
            want_rem_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            rem_q      <= rem_d;
            quo_q      <= quo_d;
            dvs_q      <= dvs_d;
            result_q   <= result_d;
            sign_a_q   <= sign_a_d;
            sign_b_q   <= sign_b_d;
            want_rem_q <= want_rem_d;
        end
    end

    assign busy   = (state_q != IDLE);
    assign done   = (state_q == DONE);
    assign result = result_q;

endmodule

// File: tb/tb_div_sequencer.sv
// Self-checking bench for div_sequencer: a reference model pushes expected
// results into a scoreboard queue at issue, and they are popped on done.
module tb_div_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        flush;
    logic [2:0]  funct3;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic        stall;
    logic        busy;
    logic        done;
    logic [31:0] result;

    int          errors = 0;
    int          checks = 0;
    int          done_seen = 0;
    logic [31:0] exp_q[$];

    always #5 clk = ~clk;

    div_sequencer #(.XLEN(32)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .flush  (flush),
        .funct3 (funct3),
        .op_a   (op_a),
        .op_b   (op_b),
        .stall  (stall),
        .busy   (busy),
        .done   (done),
        .result (result)
    );

    // Counts done pulses; sampled at the edge, so it reflects completed cycles.
    always @(posedge clk) if (done) done_seen++;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] model(input logic [2:0] f3, input logic [31:0] a,
                                          input logic [31:0] b);
        logic        sgn;
        logic [31:0] q;
        logic [31:0] r;
        sgn = ~f3[0];
        if (b == 32'd0) begin
            q = 32'hFFFF_FFFF;
            r = a;
        end else if (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            q = 32'h8000_0000;
            r = 32'd0;
        end else if (sgn) begin
            q = $signed(a) / $signed(b);
            r = $signed(a) % $signed(b);
        end else begin
            q = a / b;
            r = a % b;
        end
        return f3[1] ? r : q;
    endfunction

    // Issues one divide, holds start until done, checks latency/stall/result.
    task automatic do_div(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                          input int lat);
        int          cyc;
        int          stall_hi;
        bit          seen;
        logic [31:0] res_exp;
        @(posedge clk); #1;
        start  = 1'b1;
        funct3 = f3;
        op_a   = a;
        op_b   = b;
        exp_q.push_back(model(f3, a, b));
        cyc      = 0;
        stall_hi = 0;
        seen     = 1'b0;
        while (cyc < 100 && !seen) begin
            @(negedge clk);
            if (done) begin
                seen = 1'b1;
            end else begin
                if (stall) stall_hi++;
                @(posedge clk); #1;
                cyc++;
            end
        end
        check("done_seen", 32'(seen), 32'd1);
        check("latency", 32'(cyc), 32'(lat));
        check("stall_cycles", 32'(stall_hi), 32'(lat));
        check("stall_in_done", 32'(stall), 32'd0);
        res_exp = exp_q.pop_front();
        check("result", result, res_exp);
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
        check("done_single", 32'(done), 32'd0);
        check("result_hold", result, res_exp);
    endtask

    typedef struct {
        logic [2:0]  f3;
        logic [31:0] a;
        logic [31:0] b;
        int          lat;
    } vec_t;

    vec_t vecs[12] = '{
        '{3'b101, 32'd100,        32'd7,        34},
        '{3'b111, 32'd100,        32'd7,        34},
        '{3'b100, 32'hFFFF_FFF9,  32'd2,        34},
        '{3'b110, 32'hFFFF_FFF9,  32'd2,        34},
        '{3'b100, 32'hFFFF_FFF9,  32'hFFFF_FFFE, 34},
        '{3'b100, 32'h0000_1234,  32'd0,        1},
        '{3'b111, 32'h0000_1234,  32'd0,        1},
        '{3'b100, 32'h8000_0000,  32'hFFFF_FFFF, 1},
        '{3'b110, 32'h8000_0000,  32'hFFFF_FFFF, 1},
        '{3'b101, 32'h8000_0000,  32'hFFFF_FFFF, 34},
        '{3'b101, 32'hFFFF_FFFF,  32'd1,        34},
        '{3'b111, 32'd5,          32'hFFFF_FFFF, 34}
    };

    initial begin
        int          d0;
        logic [31:0] res_before;

        rst    = 1'b0;
        start  = 1'b0;
        flush  = 1'b0;
        funct3 = 3'b000;
        op_a   = '0;
        op_b   = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_stall", 32'(stall), 32'd0);
        check("rst_result", result, 32'd0);
        @(posedge clk); #1;
        rst = 1'b1;

        foreach (vecs[i]) do_div(vecs[i].f3, vecs[i].a, vecs[i].b, vecs[i].lat);

        for (int i = 0; i < 4; i++) begin
            logic [2:0]  f3;
            logic [31:0] a;
            logic [31:0] b;
            f3 = 3'($urandom_range(4, 7));
            a  = $urandom;
            b  = $urandom | 32'd1;
            do_div(f3, a, b, 34);
        end

        // Non-divide start is ignored.
        d0 = done_seen;
        @(posedge clk); #1;
        start  = 1'b1;
        funct3 = 3'b000;
        op_a   = 32'd5;
        op_b   = 32'd5;
        repeat (3) begin
            @(negedge clk);
            check("ign_stall", 32'(stall), 32'd0);
            check("ign_busy", 32'(busy), 32'd0);
            @(posedge clk); #1;
        end
        start = 1'b0;
        @(negedge clk);
        check("ign_done", 32'(done_seen), 32'(d0));

        // Flush in IDLE beats start.
        @(posedge clk); #1;
        start  = 1'b1;
        flush  = 1'b1;
        funct3 = 3'b101;
        @(negedge clk);
        check("idle_flush_stall", 32'(stall), 32'd0);
        @(posedge clk); #1;
        start = 1'b0;
        flush = 1'b0;
        @(negedge clk);
        check("idle_flush_busy", 32'(busy), 32'd0);

        // Flush at cycle 10 of a DIVU, then a new divide at cycle 12.
        d0         = done_seen;
        res_before = result;
        @(posedge clk); #1;
        start  = 1'b1;
        funct3 = 3'b101;
        op_a   = 32'd100;
        op_b   = 32'd7;
        repeat (10) @(posedge clk);
        #1;
        start = 1'b0;
        flush = 1'b1;
        @(negedge clk);
        check("flush_busy_c10", 32'(busy), 32'd1);
        @(posedge clk); #1;
        flush = 1'b0;
        @(negedge clk);
        check("flush_busy_c11", 32'(busy), 32'd0);
        check("flush_stall_c11", 32'(stall), 32'd0);
        check("flush_result", result, res_before);
        do_div(3'b101, 32'd9, 32'd3, 34);
        check("flush_done_count", 32'(done_seen), 32'(d0 + 1));

        // Reset at cycle 5 of a divide discards it.
        d0 = done_seen;
        @(posedge clk); #1;
        start  = 1'b1;
        funct3 = 3'b101;
        op_a   = 32'd100;
        op_b   = 32'd7;
        repeat (5) @(posedge clk);
        #1;
        rst   = 1'b0;
        start = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_result", result, 32'd0);
        check("mid_rst_stall", 32'(stall), 32'd0);
        repeat (40) @(posedge clk);
        @(negedge clk);
        check("mid_rst_done", 32'(done_seen), 32'(d0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/div_sequencer.md
Name: div_sequencer

Overview:
- Multi-cycle controller and radix-2 restoring datapath for RV32M DIV/DIVU/REM/REMU.
- The EX-stage ALU handles MUL* combinationally but does not divide. This block takes a divide request from EX, stalls the pipeline while it iterates one quotient bit per cycle, and returns the 32-bit result to the EX result mux.
- It owns the only divider in the core and sequences it: accept, iterate, sign-fix, complete.

Parameters:
- XLEN, 32, operand/result width. The iteration counter is clog2(XLEN)+1 bits.

Ports:
- clk  in  1  core clock; all state updates on rising edge
- rst  in  1  synchronous, active-low reset
- start  in  1  EX holds a divide-class instruction; held high until stall drops
- flush  in  1  EX instruction squashed (branch/jump redirect)
- funct3  in  3  inst[14:12]: 100 DIV, 101 DIVU, 110 REM, 111 REMU
- op_a  in  XLEN  dividend (rs1)
- op_b  in  XLEN  divisor (rs2)
- stall  out  1  freeze IF/ID/EX to hazard unit
- busy  out  1  state != IDLE
- done  out  1  one-cycle pulse; result valid
- result  out  XLEN  quotient or remainder

Behaviour:
- Reset (rst==0 at a clock edge) forces:
  - state=IDLE
  - counter=0
  - result=0, done=0, busy=0
  - all internal registers=0
  - Applies in any state; an operation in progress is discarded with no done pulse.
- States: IDLE, CALC, FIX, DONE.
- IDLE:
  - Accept when start=1 && funct3[2]=1 && flush=0.
  - start with funct3[2]=0 is ignored; stall stays 0.
  - On accept, latch:
    - signed = ~funct3[0]
    - want_rem = funct3[1]
    - sign_a = signed & op_a[XLEN-1], sign_b = signed & op_b[XLEN-1]
    - |op_a| and |op_b| (raw values when unsigned)
    - original op_a
  - Next state on accept:
    - op_b==0 → DONE with quotient=all ones, remainder=op_a (either signedness).
    - signed && op_a==0x80000000 && op_b==0xFFFFFFFF → DONE with quotient=0x80000000, remainder=0.
    - Otherwise → CALC with counter=XLEN, remainder reg=0, quotient reg=|op_a|.
- CALC, one bit per cycle:
  - {rem,quo} shifted left 1; trial = rem_shifted − |op_b| (XLEN+1 bits).
  - If trial ≥ 0: rem=trial and quo LSB=1; else quo LSB=0.
  - counter decrements; on the cycle counter reaches 1 → FIX.
  - Exactly XLEN cycles in CALC.
- FIX:
  - quotient negated (two's complement) if sign_a^sign_b.
  - remainder negated if sign_a.
  - result register loaded with remainder if want_rem, else quotient. → DONE.
  - Special cases load result directly on accept and skip FIX.
- DONE: done=1 for this cycle only; stall=0; start is ignored (same instruction still present); → IDLE.
- stall, combinational: stall = (state==IDLE && accept) | state==CALC | state==FIX.
  - Deasserted in DONE so the pipeline advances with result valid.
- Latency, accept cycle = cycle 0:
  - normal: CALC cycles 1..XLEN, FIX cycle XLEN+1, DONE (done=1) cycle XLEN+2 = 34.
  - special case: done=1 at cycle 1.
- result holds its value after DONE until the next accepted operation's result is loaded.
- flush:
  - In CALC/FIX: next state IDLE, no done pulse, stall drops the following cycle, result unchanged.
  - In IDLE: flush has priority over start (no accept).
  - In DONE: no effect; done still pulses.
- Simultaneous rst=0 and flush: reset wins.
- Back-to-back divides: the second start is seen in the IDLE cycle after DONE and accepted there. Minimum spacing is XLEN+3 cycles.

Test Plan:
- DIVU, op_a=100, op_b=7 → stall high cycles 0..33; done=1 at cycle 34; result=14. Same operands with REMU → result=2.
- DIV, op_a=-7 (0xFFFFFFF9), op_b=2 → result=0xFFFFFFFD (-3). REM with the same operands → 0xFFFFFFFF (-1). DIV -7/-2 → 3.
- DIV 0x1234/0 → done at cycle 1, result=0xFFFFFFFF. REMU 0x1234/0 → result=0x1234.
- DIV 0x80000000/0xFFFFFFFF → done at cycle 1, result=0x80000000. REM with the same operands → 0.
- Flush at cycle 10 of DIVU 100/7 → state IDLE at cycle 11, done never pulses, stall=0 from cycle 11. A new DIVU 9/3 at cycle 12 → done at cycle 46, result=3.
- Control cases:
  - start with funct3=000 → stall=0, busy=0, no done.
  - rst=0 at cycle 5 of a divide → busy=0, result=0 next cycle, no done.
  - start held high through DONE → exactly one done pulse.
